// File: rtl/mul8_resolve_pkg.sv
// Shared types and constants for the multiplier carry-propagate resolver.
// Holds the sequencer state encoding and the chunk-count derivation.
package mul8_resolve_pkg;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_ACC  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Number of adder passes needed to cover the full product width.
    function automatic int calc_nchunk(input int chunk);
        return PROD_W / chunk;
    endfunction

endpackage

// File: rtl/resolve_chunk_add_yjy.sv
// Combinational CHUNK-bit adder with carry-in/carry-out; the resolver
// reuses one instance for every chunk of the redundant pair.
module resolve_chunk_add_yjy #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];

endmodule

// File: rtl/mul8_resolve_yjy.sv
// Sequential resolver: adds the two redundant product vectors CHUNK bits per
// cycle and optionally accumulates the sign-extended product.
module mul8_resolve_yjy
    import mul8_resolve_pkg::*;
#(
    parameter int    UUID  = 0,
    parameter string NAME  = "",
    parameter int    CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wi_valid,
    output logic        wo_ready,
    input  logic [15:0] wi_compr1_16bit,
    input  logic [15:0] wi_compr0_16bit,
    input  logic        wi_acc_en,
    input  logic        wi_acc_clr,
    output logic        wo_valid,
    input  logic        wi_ready,
    output logic [15:0] wo_prod_16bit,
    output logic [31:0] wo_acc_32bit
);

    localparam int NCHUNK = calc_nchunk(CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t              r_state;
    logic [PROD_W-1:0]   r_op1;
    logic [PROD_W-1:0]   r_op0;
    logic                r_acc_en;
    logic                r_acc_clr;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic [CHUNK-1:0]    r_prod_chunk [NCHUNK];

    logic [CHUNK-1:0]    w_op1_chunk [NCHUNK];
    logic [CHUNK-1:0]    w_op0_chunk [NCHUNK];
    logic [CHUNK-1:0]    w_sum;
    logic                w_cout;
    logic [PROD_W-1:0]   w_prod;
    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_acc_base;
    logic [ACC_W-1:0]    w_prod_sext;

    assign w_accept = (r_state == ST_IDLE) && wi_valid;
    assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_op1_chunk[gi]            = r_op1[gi*CHUNK +: CHUNK];
            assign w_op0_chunk[gi]            = r_op0[gi*CHUNK +: CHUNK];
            assign w_prod[gi*CHUNK +: CHUNK]  = r_prod_chunk[gi];

            // Each product slice only loads on the ADD pass that targets it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prod_chunk[gi] <= '0;
                end else if (r_state == ST_ADD && r_idx == IDX_W'(gi)) begin
                    r_prod_chunk[gi] <= w_sum;
                end
            end
        end
    endgenerate

    resolve_chunk_add_yjy #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .i_a    (w_op1_chunk[r_idx]),
        .i_b    (w_op0_chunk[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_base  = r_acc_clr ? '0 : r_acc;
    assign w_prod_sext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op1     <= '0;
            r_op0     <= '0;
            r_acc_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op1     <= wi_compr1_16bit;
                        r_op0     <= wi_compr0_16bit;
                        r_acc_en  <= wi_acc_en;
                        r_acc_clr <= wi_acc_clr;
                        r_carry   <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= ST_ADD;
                        // A clear without accumulation still resets the running total.
                        if (wi_acc_clr && !wi_acc_en) begin
                            r_acc <= '0;
                        end
                    end
                end
                ST_ADD: begin
                    // Carry out of the top chunk is dropped when the index wraps.
                    r_carry <= w_last ? 1'b0 : w_cout;
                    r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= r_acc_en ? ST_ACC : ST_HOLD;
                    end
                end
                ST_ACC: begin
                    r_acc   <= w_acc_base + w_prod_sext;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (wi_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wo_ready      = (r_state == ST_IDLE);
    assign wo_valid      = (r_state == ST_HOLD);
    assign wo_prod_16bit = w_prod;
    assign wo_acc_32bit  = r_acc;

endmodule

// File: tb/tb_mul8_resolve_yjy.sv
// Directed bench for the resolver: CHUNK=4 main instance plus a CHUNK=8
// instance for the wider-chunk latency case.
module tb_mul8_resolve_yjy;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        wi_valid = 1'b0;
    logic        wo_ready;
    logic [15:0] wi_compr1_16bit = '0;
    logic [15:0] wi_compr0_16bit = '0;
    logic        wi_acc_en = 1'b0;
    logic        wi_acc_clr = 1'b0;
    logic        wo_valid;
    logic        wi_ready = 1'b0;
    logic [15:0] wo_prod_16bit;
    logic [31:0] wo_acc_32bit;

    logic        s8_valid = 1'b0;
    logic        s8_ready_out;
    logic [15:0] s8_c1 = '0;
    logic [15:0] s8_c0 = '0;
    logic        s8_valid_out;
    logic        s8_ready_in = 1'b0;
    logic [15:0] s8_prod;
    logic [31:0] s8_acc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul8_resolve_yjy #(
        .UUID  (1),
        .NAME  ("dut4"),
        .CHUNK (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .wi_valid        (wi_valid),
        .wo_ready        (wo_ready),
        .wi_compr1_16bit (wi_compr1_16bit),
        .wi_compr0_16bit (wi_compr0_16bit),
        .wi_acc_en       (wi_acc_en),
        .wi_acc_clr      (wi_acc_clr),
        .wo_valid        (wo_valid),
        .wi_ready        (wi_ready),
        .wo_prod_16bit   (wo_prod_16bit),
        .wo_acc_32bit    (wo_acc_32bit)
    );

    mul8_resolve_yjy #(
        .UUID  (2),
        .NAME  ("dut8"),
        .CHUNK (8)
    ) u_dut8 (
        .clk             (clk),
        .rst             (rst),
        .wi_valid        (s8_valid),
        .wo_ready        (s8_ready_out),
        .wi_compr1_16bit (s8_c1),
        .wi_compr0_16bit (s8_c0),
        .wi_acc_en       (1'b0),
        .wi_acc_clr      (1'b0),
        .wo_valid        (s8_valid_out),
        .wi_ready        (s8_ready_in),
        .wo_prod_16bit   (s8_prod),
        .wo_acc_32bit    (s8_acc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [15:0] c1, input logic [15:0] c0,
                           input logic en, input logic clr, input logic [15:0] exp_prod,
                           input logic [31:0] exp_acc, input int exp_lat, input int hold_cyc);
        int lat;
        @(negedge clk);
        wi_valid        = 1'b1;
        wi_compr1_16bit = c1;
        wi_compr0_16bit = c0;
        wi_acc_en       = en;
        wi_acc_clr      = clr;
        @(posedge clk);
        #1;
        // Scramble the inputs: they must be ignored after acceptance.
        wi_valid        = 1'b0;
        wi_compr1_16bit = 16'($urandom);
        wi_compr0_16bit = 16'($urandom);
        wi_acc_en       = 1'($urandom);
        wi_acc_clr      = 1'($urandom);
        chk({tag, "_busy_ready"}, {31'd0, wo_ready}, 32'd0);
        lat = 0;
        while (!wo_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_prod"}, {16'd0, wo_prod_16bit}, {16'd0, exp_prod});
        chk({tag, "_acc"}, wo_acc_32bit, exp_acc);
        for (int i = 0; i < hold_cyc; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"}, {31'd0, wo_valid}, 32'd1);
            chk({tag, "_bp_ready"}, {31'd0, wo_ready}, 32'd0);
            chk({tag, "_bp_prod"}, {16'd0, wo_prod_16bit}, {16'd0, exp_prod});
            chk({tag, "_bp_acc"}, wo_acc_32bit, exp_acc);
        end
        @(negedge clk);
        wi_ready = 1'b1;
        @(posedge clk);
        #1;
        wi_ready = 1'b0;
        chk({tag, "_done_valid"}, {31'd0, wo_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, wo_ready}, 32'd1);
        $display("txn %s: 0x%04h+0x%04h en=%0d clr=%0d -> prod=0x%04h acc=0x%08h lat=%0d",
                 tag, c1, c0, en, clr, wo_prod_16bit, wo_acc_32bit, lat);
    endtask

    initial begin
        int lat;
        logic seen_valid;

        #12;
        chk("reset_ready", {31'd0, wo_ready}, 32'd1);
        chk("reset_valid", {31'd0, wo_valid}, 32'd0);
        chk("reset_prod", {16'd0, wo_prod_16bit}, 32'd0);
        chk("reset_acc", wo_acc_32bit, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_txn("basic",    16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 32'h0000_0000, 4, 0);
        run_txn("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 4, 0);
        run_txn("acc_neg",  16'hFF00, 16'h00EB, 1'b1, 1'b1, 16'hFFEB, 32'hFFFF_FFEB, 5, 3);
        run_txn("acc_pos",  16'h0060, 16'h0004, 1'b1, 1'b0, 16'h0064, 32'h0000_004F, 5, 0);
        run_txn("clr_only", 16'h0100, 16'h0200, 1'b0, 1'b1, 16'h0300, 32'h0000_0000, 4, 0);
        run_txn("acc_sext", 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 32'hFFFF_8000, 5, 0);

        // Reset during the second ADD cycle of an accumulating operation.
        @(negedge clk);
        wi_valid        = 1'b1;
        wi_compr1_16bit = 16'h5555;
        wi_compr0_16bit = 16'h1111;
        wi_acc_en       = 1'b1;
        wi_acc_clr      = 1'b0;
        @(posedge clk);
        #1;
        wi_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, wo_ready}, 32'd1);
        chk("midrst_valid", {31'd0, wo_valid}, 32'd0);
        chk("midrst_prod", {16'd0, wo_prod_16bit}, 32'd0);
        chk("midrst_acc", wo_acc_32bit, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (wo_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_valid", {31'd0, seen_valid}, 32'd0);
        $display("txn midrst: reset during ADD, valid_seen=%0d", seen_valid);
        run_txn("post_rst", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 32'h0000_0000, 4, 0);

        // Wider chunk: two passes cover the product.
        @(negedge clk);
        s8_valid = 1'b1;
        s8_c1    = 16'h80FF;
        s8_c0    = 16'h0001;
        @(posedge clk);
        #1;
        s8_valid = 1'b0;
        lat = 0;
        while (!s8_valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("c8_latency", lat, 2);
        chk("c8_prod", {16'd0, s8_prod}, 32'h0000_8100);
        chk("c8_acc", s8_acc, 32'd0);
        @(negedge clk);
        s8_ready_in = 1'b1;
        @(posedge clk);
        #1;
        s8_ready_in = 1'b0;
        chk("c8_done_ready", {31'd0, s8_ready_out}, 32'd1);
        $display("txn c8: 0x80FF+0x0001 -> prod=0x%04h lat=%0d", s8_prod, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
